// File: rtl/pio_sm_clk_sched_if.sv
// Control/status bundle between the PIO control register file and the
// per-SM clock-enable scheduler. The register file is the master; the
// scheduler is the slave.
interface pio_sm_clk_sched_if #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
);
  logic [NUM_SM-1:0]        sm_en;
  logic [NUM_SM-1:0]        clkdiv_restart;
  logic [NUM_SM-1:0]        sm_restart;
  logic [NUM_SM*INT_W-1:0]  clkdiv_int;
  logic [NUM_SM*FRAC_W-1:0] clkdiv_frac;
  logic [NUM_SM-1:0]        sm_tick;
  logic [NUM_SM-1:0]        sm_rst;
  logic [NUM_SM-1:0]        sm_active;

  modport master (
    output sm_en, clkdiv_restart, sm_restart, clkdiv_int, clkdiv_frac,
    input  sm_tick, sm_rst, sm_active
  );

  modport slave (
    input  sm_en, clkdiv_restart, sm_restart, clkdiv_int, clkdiv_frac,
    output sm_tick, sm_rst, sm_active
  );
endinterface

// File: rtl/pio_sm_clk_sched.sv
// Per-state-machine clock-enable scheduler. Each SM owns an independent
// fractional divider (integer period counter plus fractional accumulator)
// that emits a one-cycle execute tick at an average rate of
// int + frac/256 cycles. Everything runs on the shared system clock.
module pio_sm_clk_sched #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pio_sm_clk_sched_if.slave bus
);

  // Counter/period width: one extra bit so a zero integer field can mean 65536.
  localparam int CW = INT_W + 1;

  logic [NUM_SM-1:0] rst_q;
  logic [NUM_SM-1:0] active_q;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    logic [INT_W-1:0]  int_fld;
    logic [FRAC_W-1:0] frac_fld;
    logic [CW-1:0]     int_eff;
    logic [FRAC_W-1:0] frac_eff;
    logic [FRAC_W:0]   acc_sum;
    logic              tick_ev;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     per_q, per_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              tick_q, tick_d;

    assign int_fld  = bus.clkdiv_int[INT_W*g +: INT_W];
    assign frac_fld = bus.clkdiv_frac[FRAC_W*g +: FRAC_W];
    // A zero integer field selects the maximum period and disables the fraction.
    assign int_eff  = (int_fld == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, int_fld};
    assign frac_eff = (int_fld == '0) ? '0 : frac_fld;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_eff};
    assign tick_ev  = bus.sm_en[g] && (cnt_q == per_q - CW'(1));

    // Next divider state: restart beats ticking; a disabled SM simply holds.
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      acc_d  = acc_q;
      tick_d = 1'b0;
      if (bus.clkdiv_restart[g]) begin
        cnt_d = '0;
        acc_d = '0;
        per_d = CW'(1);
      end else if (tick_ev) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        acc_d  = acc_sum[FRAC_W-1:0];
        per_d  = int_eff + CW'(acc_sum[FRAC_W]);
      end else if (bus.sm_en[g]) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Divider state register; reset leaves per=1 so the first enabled cycle ticks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        per_q  <= CW'(1);
        acc_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        acc_q  <= acc_d;
        tick_q <= tick_d;
      end
    end

    assign bus.sm_tick[g] = tick_q;
  end

  // SM restart strobe and enable mirror, both simply delayed by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q    <= '0;
      active_q <= '0;
    end else begin
      rst_q    <= bus.sm_restart;
      active_q <= bus.sm_en;
    end
  end

  assign bus.sm_rst    = rst_q;
  assign bus.sm_active = active_q;

endmodule

// File: tb/tb_pio_sm_clk_sched.sv
// Self-checking bench for pio_sm_clk_sched. A reference model written in
// cumulative fixed-point phase terms predicts each cycle's outputs and
// pushes them to a scoreboard queue; they are popped and compared after
// the clock edge. Directed checks on logged tick times cover the
// spacing cases.
module tb_pio_sm_clk_sched;

  logic clk;
  logic rst_n;

  pio_sm_clk_sched_if #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) bus ();

  pio_sm_clk_sched #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [63:0] int_bus;
  logic [31:0] frac_bus;
  assign bus.clkdiv_int  = int_bus;
  assign bus.clkdiv_frac = frac_bus;

  // Model: enabled cycles since divider restart, accumulated phase in 1/256
  // cycle units, and the enabled-cycle index of the next tick.
  longint m_e[4];
  longint m_p[4];
  longint m_next[4];

  logic [11:0] exp_q[$];

  int tick_cyc[4][64];
  int tick_n[4];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_cfg(input int i, input logic [15:0] iv, input logic [7:0] fv);
    int_bus[16*i +: 16] = iv;
    frac_bus[8*i +: 8]  = fv;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_e[i] = 0; m_p[i] = 0; m_next[i] = 0;
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 4; i++) tick_n[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] en, input logic [3:0] cdr, input logic [3:0] smr);
    logic [3:0] t;
    longint iv, fv;
    t = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (cdr[i]) begin
        m_e[i] = 0; m_p[i] = 0; m_next[i] = 0;
      end else if (en[i]) begin
        if (m_e[i] == m_next[i]) begin
          t[i] = 1'b1;
          iv = longint'(int_bus[16*i +: 16]);
          fv = longint'(frac_bus[8*i +: 8]);
          if (iv == 0) begin
            iv = 65536;
            fv = 0;
          end
          m_p[i]    = m_p[i] + iv * 256 + fv;
          m_next[i] = m_p[i] / 256;
        end
        m_e[i] = m_e[i] + 1;
      end
    end
    exp_q.push_back({en, smr, t});
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [3:0] cdr, input logic [3:0] smr);
    logic [11:0] exp_v;
    bus.sm_en          = en;
    bus.clkdiv_restart = cdr;
    bus.sm_restart     = smr;
    model_step(en, cdr, smr);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checkOutput("sm_tick",   32'(bus.sm_tick),   32'(exp_v[3:0]));
    checkOutput("sm_rst",    32'(bus.sm_rst),    32'(exp_v[7:4]));
    checkOutput("sm_active", 32'(bus.sm_active), 32'(exp_v[11:8]));
    for (int i = 0; i < 4; i++) begin
      if (bus.sm_tick[i] === 1'b1) begin
        if (tick_n[i] < 64) tick_cyc[i][tick_n[i]] = cyc;
        tick_n[i]++;
      end
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.sm_en          = '0;
    bus.clkdiv_restart = '0;
    bus.sm_restart     = '0;
    int_bus            = '0;
    frac_bus           = '0;
    set_cfg(0, 16'd1, 8'h00);
    set_cfg(1, 16'd3, 8'h00);
    set_cfg(2, 16'd2, 8'h80);
    set_cfg(3, 16'd4, 8'h00);
    model_reset();
    clear_log();

    #1;
    checkOutput("reset_tick",   32'(bus.sm_tick),   32'h0);
    checkOutput("reset_rst",    32'(bus.sm_rst),    32'h0);
    checkOutput("reset_active", 32'(bus.sm_active), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SM0 at int=1: tick every enabled cycle.
    for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b0000, 4'b0000);
    clear_log();
    for (int k = 0; k < 5; k++) applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkOutput("sm0_div1_count", 32'(tick_n[0]), 32'd5);

    // SM1 at int=3.
    clear_log();
    for (int k = 0; k < 10; k++) applyStimulus(4'b0011, 4'b0000, 4'b0000);
    checkOutput("sm1_count", 32'(tick_n[1]), 32'd4);
    checkOutput("sm1_gap", 32'(tick_cyc[1][1] - tick_cyc[1][0]), 32'd3);

    // SM2 at 2.5: alternating spacing, 11th tick 25 cycles after the 1st.
    clear_log();
    for (int k = 0; k < 30; k++) applyStimulus(4'b0111, 4'b0000, 4'b0000);
    checkOutput("sm2_gap_a", 32'(tick_cyc[2][1] - tick_cyc[2][0]), 32'd2);
    checkOutput("sm2_gap_b", 32'(tick_cyc[2][2] - tick_cyc[2][1]), 32'd3);
    checkOutput("sm2_span11", 32'(tick_cyc[2][10] - tick_cyc[2][0]), 32'd25);

    // SM3 pause mid-period at cnt=2, reconfigure during the pause.
    applyStimulus(4'b0111, 4'b1000, 4'b0000);
    clear_log();
    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) set_cfg(3, 16'd6, 8'h00);
      applyStimulus(4'b0111, 4'b0000, 4'b0000);
    end
    for (int k = 0; k < 12; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("sm3_count", 32'(tick_n[3]), 32'd3);
    checkOutput("sm3_pause_gap", 32'(tick_cyc[3][1] - tick_cyc[3][0]), 32'd11);
    checkOutput("sm3_new_period", 32'(tick_cyc[3][2] - tick_cyc[3][1]), 32'd6);

    // SM0 and SM2 at int=5, realigned by a joint divider restart.
    set_cfg(0, 16'd5, 8'h00);
    set_cfg(2, 16'd5, 8'h00);
    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 4'b0001, 4'b0000);
    for (int k = 0; k < 2; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    clear_log();
    applyStimulus(4'b1111, 4'b0101, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b1111, 4'b0000, (k == 7) ? 4'b1000 : 4'b0000);
    end
    checkOutput("align_count0", 32'(tick_n[0]), 32'd4);
    checkOutput("align_count2", 32'(tick_n[2]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("align_cycle", 32'(tick_cyc[2][k]), 32'(tick_cyc[0][k]));
    end

    // SM1 with a zero integer field: 65536-cycle period, fraction ignored.
    set_cfg(1, 16'd0, 8'h40);
    clear_log();
    applyStimulus(4'b1111, 4'b0010, 4'b0000);
    for (int k = 0; k < 65540; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("sm1_max_count", 32'(tick_n[1]), 32'd2);
    checkOutput("sm1_max_gap", 32'(tick_cyc[1][1] - tick_cyc[1][0]), 32'd65536);

    // Asynchronous reset mid-period with outputs active.
    set_cfg(1, 16'd3, 8'h00);
    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 4'b0000, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_tick",   32'(bus.sm_tick),   32'h0);
    checkOutput("async_rst",    32'(bus.sm_rst),    32'h0);
    checkOutput("async_active", 32'(bus.sm_active), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_log();
    for (int k = 0; k < 12; k++) applyStimulus(4'b1111, 4'b0000, 4'b0000);
    checkOutput("post_reset_first", 32'(tick_cyc[3][0]), 32'(tick_cyc[0][0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_sm_clk_sched.md
Name: pio_sm_clk_sched

Overview:
Per-state-machine clock-enable scheduler for the PIO block. It takes each SM's CLKDIV integer/fraction fields and CTRL bits (enable, restart, clkdiv_restart) from the control register file. It emits a single-cycle execution tick per SM at the programmed fractional rate, plus a one-cycle SM restart strobe. All SMs share the system clock; no derived clocks are generated.

Parameters:
NUM_SM, 4, number of state machines scheduled
INT_W, 16, width of divider integer field
FRAC_W, 8, width of divider fractional field

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
sm_en  input  NUM_SM  CTRL SM_ENABLE level per SM
clkdiv_restart  input  NUM_SM  CTRL CLKDIV_RESTART one-cycle strobe per SM
sm_restart  input  NUM_SM  CTRL SM_RESTART one-cycle strobe per SM
clkdiv_int  input  NUM_SM*INT_W  SM i integer divisor at [INT_W*i +: INT_W] (CLKDIV[31:16])
clkdiv_frac  input  NUM_SM*FRAC_W  SM i fractional divisor at [FRAC_W*i +: FRAC_W] (CLKDIV[15:8])
sm_tick  output  NUM_SM  registered one-cycle execute enable per SM
sm_rst  output  NUM_SM  registered one-cycle SM internal-state restart per SM
sm_active  output  NUM_SM  registered copy of sm_en

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0.
  - per-SM state: cnt=0 (17b), acc=0 (FRAC_W b), per=1 (17b).
  - Reset deasserted mid-period: the period restarts from these values.
- Effective integer: int_eff = 65536 when clkdiv_int field == 0, else the field value. When the integer field == 0, frac is treated as 0.
- Per SM i, evaluated every cycle N. All outputs are registered and appear in cycle N+1 (latency 1).
- Priority 1, clkdiv_restart[i]=1:
  - cnt<=0, acc<=0, per<=1.
  - sm_tick[i]<=0 that cycle, regardless of sm_en.
- Priority 2, sm_en[i]=1 and cnt==per-1 (tick event):
  - sm_tick[i]<=1, cnt<=0.
  - {c,acc}<=acc+frac (FRAC_W+1-bit add).
  - per<=int_eff+c.
- Priority 3, sm_en[i]=1, no tick event: cnt<=cnt+1, sm_tick[i]<=0.
- sm_en[i]=0: cnt, acc and per hold (pause, not reset); sm_tick[i]<=0.
  - On re-enable, counting resumes from the held cnt.
- First tick: after reset or clkdiv_restart, per=1, so the first enabled cycle produces a tick. Subsequent periods follow the programmed divisor.
- Divider config is sampled only at tick events. Changes mid-period take effect from the following period. A change never truncates or extends the current period.
- Average period = int + frac/256 cycles.
  - int=1 frac=0: tick every enabled cycle (sm_tick held high).
  - Max period 65536 cycles; cnt never exceeds 65535.
- sm_restart[i]=1 in cycle N -> sm_rst[i]=1 in cycle N+1 only, independent of sm_en[i]. It does not affect divider state.
- Same-cycle sm_restart[i] and clkdiv_restart[i]: both actions occur (sm_rst pulse plus divider reset).
- Multiple clkdiv_restart bits in one cycle: the selected SMs get identical divider phase. With equal config and enables, their ticks stay cycle-aligned indefinitely.
- sm_active[i] <= sm_en[i] each cycle.
- SMs are fully independent; there is no cross-SM arbitration or shared counter.

Test Plan:
- Reset, SM0 int=1 frac=0, sm_en=0001 from cycle 5 -> sm_tick[0]=1 continuously from cycle 6; other ticks 0; sm_active=0001 from cycle 6.
- SM1 int=3 frac=0, enable at cycle 10 -> sm_tick[1] at cycles 11, 14, 17, 20; clkdiv_int=0 -> ticks 65536 cycles apart after the first.
- SM2 int=2 frac=0x80 -> tick spacing after the first tick alternates 2,3,2,3; the 11th tick lands exactly 25 cycles after the 1st.
- SM3 int=4: deassert sm_en for 7 cycles mid-period (cnt=2), then re-enable -> next tick 2 enabled cycles later; no ticks during the pause. Change int to 6 mid-period -> current period still 4, next period 6.
- SM0 int=5 and SM2 int=5 out of phase; clkdiv_restart=0101 in cycle N -> no tick at N+1 for either; both tick in the first enabled cycle after N, then every 5 cycles, aligned. sm_restart=1000 -> sm_rst=1000 for exactly one cycle, SM3 tick cadence unchanged.
- Drop rst_n asynchronously mid-period with ticks running -> sm_tick, sm_rst and sm_active go 0 immediately, without waiting for a clock edge. After release, first enabled cycle ticks.
